// File: rtl/threshold_pkg.sv
// Shared definitions for the threshold datapath: FSM states and default image geometry
// used by the box filter, memory readers and threshold stage.
package threshold_pkg;

    localparam int DEFAULT_WIDTH_BITS  = 8;
    localparam int DEFAULT_HEIGHT_BITS = 8;
    localparam int DEFAULT_DATA_BITS   = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } thresholdState_t;

endpackage

// File: rtl/threshold_compare.sv
// Combinational foreground decision: pixel > (threshold - offset), optionally inverted.
// Wide signed arithmetic means t' below zero or above full scale needs no saturation.
module threshold_compare #(
    parameter int DATA_BITS   = 8,
    parameter int OFFSET_BITS = 8
) (
    input  logic [DATA_BITS-1:0]          pixel,
    input  logic [DATA_BITS-1:0]          threshold,
    input  logic signed [OFFSET_BITS-1:0] offset,
    input  logic                          invert,
    output logic                          result
);

    localparam int CMP_BITS = ((OFFSET_BITS > DATA_BITS) ? OFFSET_BITS : DATA_BITS) + 2;

    logic signed [CMP_BITS-1:0] pixelExt;
    logic signed [CMP_BITS-1:0] thresholdExt;
    logic signed [CMP_BITS-1:0] offsetExt;
    logic signed [CMP_BITS-1:0] adjustedThreshold;

    assign pixelExt          = $signed({{(CMP_BITS-DATA_BITS){1'b0}}, pixel});
    assign thresholdExt      = $signed({{(CMP_BITS-DATA_BITS){1'b0}}, threshold});
    assign offsetExt         = $signed({{(CMP_BITS-OFFSET_BITS){offset[OFFSET_BITS-1]}}, offset});
    assign adjustedThreshold = thresholdExt - offsetExt;
    assign result            = (pixelExt > adjustedThreshold) ^ invert;

endmodule

// File: rtl/adaptive_threshold_pipe.sv
// Raster-order adaptive threshold stage: fetches pixel/threshold pairs, writes one binary result
// per pixel. Define THRESHOLD_COUNT_EN to add the oOnesCount foreground counter port.
module adaptive_threshold_pipe
    import threshold_pkg::*;
#(
    parameter int WIDTH_BITS   = DEFAULT_WIDTH_BITS,
    parameter int HEIGHT_BITS  = DEFAULT_HEIGHT_BITS,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int OFFSET_BITS  = 8,
    parameter int READ_LATENCY = 1,
    parameter bit AUTO_START   = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          iStart,
    input  logic signed [OFFSET_BITS-1:0] iOffset,
    input  logic                          iInvert,
    output logic [WIDTH_BITS-1:0]         oImageCol,
    output logic [HEIGHT_BITS-1:0]        oImageRow,
    input  logic [DATA_BITS-1:0]          iImageData,
    output logic [WIDTH_BITS-1:0]         oThresholdCol,
    output logic [HEIGHT_BITS-1:0]        oThresholdRow,
    input  logic [DATA_BITS-1:0]          iThresholdData,
    output logic [WIDTH_BITS-1:0]         oResultCol,
    output logic [HEIGHT_BITS-1:0]        oResultRow,
    output logic                          oResultData,
    output logic                          oResultWren,
    output logic                          finished
`ifdef THRESHOLD_COUNT_EN
    ,
    output logic [WIDTH_BITS+HEIGHT_BITS:0] oOnesCount
`endif
);

    thresholdState_t stateReg, stateNext;
    logic                          autoArmedReg;
    logic [2:0]                    drainCountReg;
    logic [WIDTH_BITS-1:0]         colReg;
    logic [HEIGHT_BITS-1:0]        rowReg;
    logic signed [OFFSET_BITS-1:0] offsetReg;
    logic                          invertReg;
    logic                          startFrame;
    logic                          lastAddress;
    logic                          compareResult;

    logic [READ_LATENCY-1:0] pipeValidReg;
    logic [WIDTH_BITS-1:0]   pipeColReg [READ_LATENCY];
    logic [HEIGHT_BITS-1:0]  pipeRowReg [READ_LATENCY];

    assign lastAddress = (&colReg) && (&rowReg);

    always_comb begin
        stateNext  = stateReg;
        startFrame = 1'b0;
        case (stateReg)
            IDLE: begin
                if (iStart || autoArmedReg) begin
                    stateNext  = RUN;
                    startFrame = 1'b1;
                end
            end
            RUN: begin
                if (lastAddress) stateNext = DRAIN;
            end
            DRAIN: begin
                // One extra cycle beyond the memory latency covers the result register.
                if (drainCountReg == 3'(READ_LATENCY)) stateNext = DONE;
            end
            DONE: begin
                if (iStart) begin
                    stateNext  = RUN;
                    startFrame = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateReg      <= IDLE;
            autoArmedReg  <= AUTO_START;
            drainCountReg <= 3'd0;
            colReg        <= '0;
            rowReg        <= '0;
            offsetReg     <= '0;
            invertReg     <= 1'b0;
        end else begin
            stateReg      <= stateNext;
            autoArmedReg  <= 1'b0;
            drainCountReg <= (stateReg == DRAIN) ? drainCountReg + 3'd1 : 3'd0;
            if (startFrame) begin
                colReg    <= '0;
                rowReg    <= '0;
                offsetReg <= iOffset;
                invertReg <= iInvert;
            end else if (stateReg == RUN && !lastAddress) begin
                colReg <= colReg + 1'b1;
                if (&colReg) rowReg <= rowReg + 1'b1;
            end
        end
    end

    assign oImageCol     = colReg;
    assign oImageRow     = rowReg;
    assign oThresholdCol = colReg;
    assign oThresholdRow = rowReg;
    assign finished      = (stateReg == DONE);

    // Address tags travel with the memory read so each result lands where it was fetched.
    always_ff @(posedge clock) begin
        if (reset) begin
            pipeValidReg <= '0;
        end else begin
            pipeValidReg[0] <= (stateReg == RUN);
            for (int i = 1; i < READ_LATENCY; i++) pipeValidReg[i] <= pipeValidReg[i-1];
        end
        pipeColReg[0] <= colReg;
        pipeRowReg[0] <= rowReg;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipeColReg[i] <= pipeColReg[i-1];
            pipeRowReg[i] <= pipeRowReg[i-1];
        end
    end

    threshold_compare #(
        .DATA_BITS  (DATA_BITS),
        .OFFSET_BITS(OFFSET_BITS)
    ) compareInst (
        .pixel    (iImageData),
        .threshold(iThresholdData),
        .offset   (offsetReg),
        .invert   (invertReg),
        .result   (compareResult)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            oResultWren <= 1'b0;
            oResultData <= 1'b0;
            oResultCol  <= '0;
            oResultRow  <= '0;
        end else begin
            oResultWren <= pipeValidReg[READ_LATENCY-1];
            if (pipeValidReg[READ_LATENCY-1]) begin
                oResultData <= compareResult;
                oResultCol  <= pipeColReg[READ_LATENCY-1];
                oResultRow  <= pipeRowReg[READ_LATENCY-1];
            end
        end
    end

`ifdef THRESHOLD_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset || startFrame) begin
            oOnesCount <= '0;
        end else if (oResultWren && oResultData) begin
            oOnesCount <= oOnesCount + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_adaptive_threshold_pipe.sv
// Bench for adaptive_threshold_pipe: a 4x4 auto-start instance with 3-cycle memories driven by a
// vector table, and a 4x4 manual-start instance with 1-cycle memories for start/reset sequences.
module tb_adaptive_threshold_pipe;

    localparam int WB    = 2;
    localparam int HB    = 2;
    localparam int DB    = 8;
    localparam int OB    = 8;
    localparam int LAT_A = 3;
    localparam int LAT_B = 1;
    localparam int NPIX  = 16;
    localparam int NVEC  = 12;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int model(input int pix, input int thr, input int off, input int inv);
        int t;
        t = thr - off;
        return ((pix > t) ? 1 : 0) ^ inv;
    endfunction

    typedef struct {
        int col;
        int row;
        int data;
    } wr_t;

    typedef struct {
        int offset;
        int invert;
        int pixel;
        int threshold;
        int expected;
    } vec_t;

    // ---------------- instance A: AUTO_START=1, READ_LATENCY=3 ----------------
    logic                 resetA = 1'b1, startA = 1'b0, invertA = 1'b0;
    logic signed [OB-1:0] offsetA = '0;
    logic [WB-1:0]        colA, thrColA, resColA;
    logic [HB-1:0]        rowA, thrRowA, resRowA;
    logic [DB-1:0]        imgDataA, thrDataA;
    logic                 resDataA, wrenA, finishedA;
`ifdef THRESHOLD_COUNT_EN
    logic [WB+HB:0]       onesA;
`endif

    adaptive_threshold_pipe #(
        .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .DATA_BITS(DB), .OFFSET_BITS(OB),
        .READ_LATENCY(LAT_A), .AUTO_START(1'b1)
    ) dutA (
        .clock(clock), .reset(resetA), .iStart(startA), .iOffset(offsetA), .iInvert(invertA),
        .oImageCol(colA), .oImageRow(rowA), .iImageData(imgDataA),
        .oThresholdCol(thrColA), .oThresholdRow(thrRowA), .iThresholdData(thrDataA),
        .oResultCol(resColA), .oResultRow(resRowA), .oResultData(resDataA),
        .oResultWren(wrenA), .finished(finishedA)
`ifdef THRESHOLD_COUNT_EN
        , .oOnesCount(onesA)
`endif
    );

    logic [DB-1:0] imgMemA [NPIX];
    logic [DB-1:0] thrMemA [NPIX];
    logic [DB-1:0] imgPipeA [LAT_A];
    logic [DB-1:0] thrPipeA [LAT_A];

    always @(posedge clock) begin
        imgPipeA[0] <= imgMemA[{rowA, colA}];
        thrPipeA[0] <= thrMemA[{thrRowA, thrColA}];
        for (int i = 1; i < LAT_A; i++) begin
            imgPipeA[i] <= imgPipeA[i-1];
            thrPipeA[i] <= thrPipeA[i-1];
        end
    end
    assign imgDataA = imgPipeA[LAT_A-1];
    assign thrDataA = thrPipeA[LAT_A-1];

    wr_t expQA[$];
    wr_t eA;
    int  frameStartA = 0, firstWrA = 0, lastWrA = 0, writesA = 0, relA = 0, expOnesA = 0;

    always @(negedge clock) begin
        if (wrenA) begin
            relA = cyc - frameStartA;
            if (writesA == 0) firstWrA = relA;
            lastWrA = relA;
            writesA++;
            if (expQA.size() == 0) begin
                check("A_unexpected_write", 1, 0);
            end else begin
                eA = expQA.pop_front();
                check($sformatf("A_write_px%0d(row*100+col*10+data)", eA.row * 4 + eA.col),
                      int'(resRowA) * 100 + int'(resColA) * 10 + int'(resDataA),
                      eA.row * 100 + eA.col * 10 + eA.data);
            end
            $display("A write cyc=%0d row=%0d col=%0d data=%0d", relA, resRowA, resColA, resDataA);
        end
    end

    // ---------------- instance B: AUTO_START=0, READ_LATENCY=1 ----------------
    logic                 resetB = 1'b1, startB = 1'b0;
    logic signed [OB-1:0] offsetB = '0;
    logic                 invertB = 1'b0;
    logic [WB-1:0]        colB, thrColB, resColB;
    logic [HB-1:0]        rowB, thrRowB, resRowB;
    logic [DB-1:0]        imgDataB, thrDataB;
    logic                 resDataB, wrenB, finishedB;
`ifdef THRESHOLD_COUNT_EN
    logic [WB+HB:0]       onesB;
`endif

    adaptive_threshold_pipe #(
        .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .DATA_BITS(DB), .OFFSET_BITS(OB),
        .READ_LATENCY(LAT_B), .AUTO_START(1'b0)
    ) dutB (
        .clock(clock), .reset(resetB), .iStart(startB), .iOffset(offsetB), .iInvert(invertB),
        .oImageCol(colB), .oImageRow(rowB), .iImageData(imgDataB),
        .oThresholdCol(thrColB), .oThresholdRow(thrRowB), .iThresholdData(thrDataB),
        .oResultCol(resColB), .oResultRow(resRowB), .oResultData(resDataB),
        .oResultWren(wrenB), .finished(finishedB)
`ifdef THRESHOLD_COUNT_EN
        , .oOnesCount(onesB)
`endif
    );

    always @(posedge clock) begin
        imgDataB <= 8'(int'({rowB, colB}) * 16);
        thrDataB <= 8'd100;
    end

    wr_t expQB[$];
    wr_t eB;
    int  frameStartB = 0, firstWrB = 0, lastWrB = 0, writesB = 0, relB = 0;

    always @(negedge clock) begin
        if (wrenB) begin
            relB = cyc - frameStartB;
            if (writesB == 0) firstWrB = relB;
            lastWrB = relB;
            writesB++;
            if (expQB.size() == 0) begin
                check("B_unexpected_write", 1, 0);
            end else begin
                eB = expQB.pop_front();
                check($sformatf("B_write_px%0d(row*100+col*10+data)", eB.row * 4 + eB.col),
                      int'(resRowB) * 100 + int'(resColB) * 10 + int'(resDataB),
                      eB.row * 100 + eB.col * 10 + eB.data);
            end
            $display("B write cyc=%0d row=%0d col=%0d data=%0d", relB, resRowB, resColB, resDataB);
        end
    end

    task automatic pushFrameB();
        wr_t w;
        for (int a = 0; a < NPIX; a++) begin
            w.col  = a % 4;
            w.row  = a / 4;
            w.data = model(a * 16, 100, 0, 0);
            expQB.push_back(w);
        end
    endtask

    task automatic startFrameB();
        writesB = 0;
        @(negedge clock);
        startB = 1'b1;
        @(posedge clock);
        #1;
        frameStartB = cyc;
        startB = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs [NVEC];

    task automatic runFrameA(input int idx);
        wr_t w;
        int  sp, pix, thr, seen;
        sp       = idx % NPIX;
        expOnesA = 0;
        for (int a = 0; a < NPIX; a++) begin
            if (a == sp) begin
                pix    = vecs[idx].pixel;
                thr    = vecs[idx].threshold;
                w.data = vecs[idx].expected;
            end else begin
                pix    = (a * 37 + idx * 53 + 11) % 256;
                thr    = (a * 91 + idx * 29 + 40) % 256;
                w.data = model(pix, thr, vecs[idx].offset, vecs[idx].invert);
            end
            imgMemA[a] = 8'(pix);
            thrMemA[a] = 8'(thr);
            w.col = a % 4;
            w.row = a / 4;
            expOnesA += w.data;
            expQA.push_back(w);
        end
        offsetA = 8'(vecs[idx].offset);
        invertA = vecs[idx].invert[0];
        writesA = 0;
        @(negedge clock);
        if (idx == 0) resetA = 1'b0;
        else startA = 1'b1;
        @(posedge clock);
        #1;
        frameStartA = cyc;
        startA  = 1'b0;
        offsetA = ~offsetA;   // must not matter once the frame has started
        invertA = ~invertA;
        @(negedge clock);
        check($sformatf("A%0d_finished_low_cycle0", idx), int'(finishedA), 0);
`ifdef THRESHOLD_COUNT_EN
        check($sformatf("A%0d_count_clear_cycle0", idx), int'(onesA), 0);
`endif
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (finishedA) begin
                seen = 1;
                break;
            end
        end
        check($sformatf("A%0d_finished_seen", idx), seen, 1);
        if (seen == 1) check($sformatf("A%0d_finished_cycle", idx), cyc - frameStartA, NPIX + LAT_A + 1);
        check($sformatf("A%0d_write_count", idx), writesA, NPIX);
        check($sformatf("A%0d_first_write_cycle", idx), firstWrA, LAT_A + 1);
        check($sformatf("A%0d_last_write_cycle", idx), lastWrA, NPIX + LAT_A);
        check($sformatf("A%0d_queue_left", idx), expQA.size(), 0);
`ifdef THRESHOLD_COUNT_EN
        check($sformatf("A%0d_ones_count", idx), int'(onesA), expOnesA);
`endif
        expQA.delete();
        $display("A frame %0d offset=%0d invert=%0d done", idx, vecs[idx].offset, vecs[idx].invert);
    endtask

    initial begin
        int seen, finHigh;
        vecs[0]  = '{0,    0, 120, 100, 1};
        vecs[1]  = '{0,    0, 100, 100, 0};
        vecs[2]  = '{5,    0,  96, 100, 1};
        vecs[3]  = '{5,    0,  95, 100, 0};
        vecs[4]  = '{-10,  0, 255, 250, 0};
        vecs[5]  = '{127,  0,   0,  20, 1};
        vecs[6]  = '{0,    1, 120, 100, 0};
        vecs[7]  = '{0,    1, 100, 100, 1};
        vecs[8]  = '{-128, 0, 255, 255, 0};
        vecs[9]  = '{127,  1,   0,   0, 0};
        vecs[10] = '{-1,   0,   0,   0, 0};
        vecs[11] = '{3,    1,   5,   8, 1};

        // Reset state of both instances.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("A_reset_col", int'(colA), 0);
        check("A_reset_row", int'(rowA), 0);
        check("A_reset_data", int'(resDataA), 0);
        check("A_reset_wren", int'(wrenA), 0);
        check("A_reset_finished", int'(finishedA), 0);
        check("B_reset_wren", int'(wrenB), 0);
        resetB = 1'b0;

        for (int v = 0; v < NVEC; v++) runFrameA(v);

        // B has been idle without iStart for the whole of the A run.
        check("B_idle_writes", writesB, 0);
        check("B_idle_finished", int'(finishedB), 0);
        check("B_idle_col", int'(colB), 0);

        // Start B, then reset it mid-frame during cycle 7.
        pushFrameB();
        startFrameB();
        repeat (8) @(negedge clock);
        resetB = 1'b1;
        @(negedge clock);
        check("B_wren_after_reset", int'(wrenB), 0);
        check("B_writes_before_reset", writesB, 6);
        expQB.delete();
        resetB = 1'b0;
        finHigh = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (finishedB) finHigh++;
        end
        check("B_no_finished_after_reset", finHigh, 0);
        check("B_no_writes_after_reset", writesB, 6);

        // Fresh full frame on B.
        pushFrameB();
        startFrameB();
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (finishedB) begin
                seen = 1;
                break;
            end
        end
        check("B_finished_seen", seen, 1);
        if (seen == 1) check("B_finished_cycle", cyc - frameStartB, NPIX + LAT_B + 1);
        check("B_write_count", writesB, NPIX);
        check("B_first_write_cycle", firstWrB, LAT_B + 1);
        check("B_last_write_cycle", lastWrB, NPIX + LAT_B);
        check("B_queue_left", expQB.size(), 0);
`ifdef THRESHOLD_COUNT_EN
        check("B_ones_count", int'(onesB), 9);
`endif
        repeat (3) @(negedge clock);
        check("B_finished_holds", int'(finishedB), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
